instr_reg_ctrl: RTL and testbench

- Write-port arbiter and FIFO sequencer for the 32-entry instruction register.
- Two requesters (e.g. stimulus generator and replay engine) share the single write port under round-robin arbitration.
- The block drives load_en, write_pointer, opcode and operands into the register, and tracks occupancy.
- It sequences read_pointer so a consumer drains stored instruction words in write order.

---
 rtl/instr_reg_ctrl.sv | 131 +++++++++++++
 tb/tb_instr_reg_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_reg_ctrl.sv
// instr_reg_ctrl: round-robin write-port arbiter and FIFO pointer sequencer
// for the instruction register. The requester datapath is combinational; only
// the pointers, the occupancy count and the last grant are held in flops.
module instr_reg_ctrl #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned OPC_W  = 6,
    parameter int unsigned OPND_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              req0_valid,
    input  logic [OPC_W-1:0]  req0_opcode,
    input  logic [OPND_W-1:0] req0_op_a,
    input  logic [OPND_W-1:0] req0_op_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [OPC_W-1:0]  req1_opcode,
    input  logic [OPND_W-1:0] req1_op_a,
    input  logic [OPND_W-1:0] req1_op_b,
    output logic              req1_ready,
    output logic              load_en,
    output logic [AW-1:0]     write_pointer,
    output logic [OPC_W-1:0]  opcode,
    output logic [OPND_W-1:0] operand_a,
    output logic [OPND_W-1:0] operand_b,
    output logic [AW-1:0]     read_pointer,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_en;
    logic          gnt0, gnt1;
    logic          push, pop;

    // Flags come from the count register only.
    assign full          = (count_q == CNT_MAX);
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign out_valid     = ~empty;
    assign write_pointer = wr_ptr_q;
    assign read_pointer  = rd_ptr_q;

    // Round-robin grant; flush, full or an asserted reset blocks every grant.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        grant_en = reset_n & ~clr & ~full;
        if (grant_en) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign load_en    = gnt0 | gnt1;
    assign push       = gnt0 | gnt1;
    assign pop        = out_valid & out_ready & ~clr;

    // Payload mux; req0 is forwarded when nothing is granted.
    always_comb begin
        opcode    = req0_opcode;
        operand_a = req0_op_a;
        operand_b = req0_op_b;
        if (gnt1) begin
            opcode    = req1_opcode;
            operand_a = req1_op_a;
            operand_b = req1_op_b;
        end
    end

    // Next pointer, count and round-robin state; flush overrides everything.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        if (clr) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            last_grant_d = 1'b1;
        end else begin
            if (push) begin
                wr_ptr_d     = wr_ptr_q + AW'(1);
                last_grant_d = gnt1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Bench for instr_reg_ctrl: directed scenarios plus randomized traffic, all
// checked against a queue-based model of the instruction FIFO and arbiter.
module tb_instr_reg_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int OW    = 6;
    localparam int DW    = 16;
    localparam int EW    = OW + 2 * DW;

    logic          clk;
    logic          reset_n;
    logic          clr;
    logic          req0_valid, req1_valid;
    logic [OW-1:0] req0_opcode, req1_opcode;
    logic [DW-1:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic          req0_ready, req1_ready;
    logic          load_en;
    logic [AW-1:0] write_pointer, read_pointer;
    logic [OW-1:0] opcode;
    logic [DW-1:0] operand_a, operand_b;
    logic          out_valid, out_ready;
    logic [AW:0]   count;
    logic          full, empty;

    instr_reg_ctrl #(.DEPTH(DEPTH), .AW(AW), .OPC_W(OW), .OPND_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr),
        .req0_valid(req0_valid), .req0_opcode(req0_opcode),
        .req0_op_a(req0_op_a), .req0_op_b(req0_op_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_opcode(req1_opcode),
        .req1_op_a(req1_op_a), .req1_op_b(req1_op_b), .req1_ready(req1_ready),
        .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .read_pointer(read_pointer), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction register array the block drives.
    logic [EW-1:0] regfile [DEPTH];
    always @(posedge clk) if (load_en) regfile[write_pointer] <= {opcode, operand_a, operand_b};

    int tests  = 0;
    int failed = 0;

    // Model: stored entries in write order, slot counters, last winner.
    logic [EW-1:0] q [$];
    int m_wr, m_rd, m_last;
    bit pend0, pend1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wr = 0; m_rd = 0; m_last = 1;
        pend0 = 0; pend1 = 0;
    endtask

    // Check one cycle against the model, then advance across the clock edge.
    task automatic step();
        int sz;
        bit fl, g0, g1, popv;
        logic [EW-1:0] d0, d1, de;
        #2;
        sz   = q.size();
        fl   = (sz == DEPTH);
        g0   = !clr && !fl && req0_valid && (!req1_valid || m_last == 1);
        g1   = !clr && !fl && req1_valid && (!req0_valid || m_last == 0);
        popv = !clr && sz > 0 && out_ready;
        d0   = {req0_opcode, req0_op_a, req0_op_b};
        d1   = {req1_opcode, req1_op_a, req1_op_b};
        de   = g1 ? d1 : d0;
        check("req0_ready", 64'(req0_ready), 64'(g0));
        check("req1_ready", 64'(req1_ready), 64'(g1));
        check("load_en", 64'(load_en), 64'(g0 | g1));
        check("write_pointer", 64'(write_pointer), 64'(m_wr));
        check("read_pointer", 64'(read_pointer), 64'(m_rd));
        check("count", 64'(count), 64'(sz));
        check("full", 64'(full), 64'(fl));
        check("empty", 64'(empty), 64'(sz == 0));
        check("out_valid", 64'(out_valid), 64'(sz > 0));
        if (g0 || g1) check("payload", 64'({opcode, operand_a, operand_b}), 64'(de));
        if (sz > 0) check("head_word", 64'(regfile[read_pointer]), 64'(q[0]));
        pend0 = req0_valid && !g0;
        pend1 = req1_valid && !g1;
        @(posedge clk);
        if (clr) begin
            q.delete();
            m_wr = 0; m_rd = 0; m_last = 1;
        end else begin
            if (popv) begin
                void'(q.pop_front());
                m_rd = (m_rd + 1) % DEPTH;
            end
            if (g0 || g1) begin
                q.push_back(de);
                m_wr   = (m_wr + 1) % DEPTH;
                m_last = g1 ? 1 : 0;
            end
        end
        #1;
    endtask

    task automatic rand_req0();
        req0_opcode = OW'($urandom); req0_op_a = DW'($urandom); req0_op_b = DW'($urandom);
    endtask

    task automatic rand_req1();
        req1_opcode = OW'($urandom); req1_op_a = DW'($urandom); req1_op_b = DW'($urandom);
    endtask

    task automatic do_clr();
        clr = 1'b1; step(); clr = 1'b0;
    endtask

    task automatic push_n(input int n);
        req1_valid = 1'b0; out_ready = 1'b0; req0_valid = 1'b1;
        for (int i = 0; i < n; i++) begin rand_req0(); step(); end
        req0_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_load_en", 64'(load_en), 64'd0);
        check("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        check("rst_ptrs", 64'({write_pointer, read_pointer}), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; clr = 1'b0; out_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rand_req0(); rand_req1();
        model_reset();
        #12;
        check_reset_vals();
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(); step();

        // ADD a=5 b=3 through the FIFO.
        req0_valid = 1'b1; req0_opcode = OW'(1); req0_op_a = DW'(5); req0_op_b = DW'(3);
        #2;
        check("add_load_en", 64'(load_en), 64'd1);
        check("add_wp", 64'(write_pointer), 64'd0);
        check("add_ready", 64'(req0_ready), 64'd1);
        step();
        req0_valid = 1'b0; out_ready = 1'b1;
        #2;
        check("add_out_valid", 64'(out_valid), 64'd1);
        check("add_result", 64'(regfile[read_pointer][2*DW-1:DW] + regfile[read_pointer][DW-1:0]), 64'd8);
        step();
        out_ready = 1'b0;
        #2;
        check("add_count", 64'(count), 64'd0);
        check("add_rp", 64'(read_pointer), 64'd1);
        step();

        // Both requesters valid: grants alternate starting at req0.
        do_clr();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            check("alt_ready0", 64'(req0_ready), 64'(i % 2 == 0));
            check("alt_wp", 64'(write_pointer), 64'(i));
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #2; check("alt_count", 64'(count), 64'd6);
        step();

        // Fill to DEPTH, blocked 33rd push, pop at full, wrap to slot 0.
        do_clr();
        push_n(DEPTH);
        req0_valid = 1'b1; req1_valid = 1'b1; rand_req0(); rand_req1();
        #2;
        check("full_flag", 64'(full), 64'd1);
        check("full_ready", 64'({req0_ready, req1_ready}), 64'd0);
        step();
        out_ready = 1'b1; step();
        #2; check("pop_at_full_count", 64'(count), 64'(DEPTH - 1));
        check("wrap_wp", 64'(write_pointer), 64'd0);
        out_ready = 1'b0; step();
        out_ready = 1'b1; step();
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;

        // Steady push+pop at count 4.
        do_clr();
        push_n(4);
        req0_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin rand_req0(); step(); end
        req0_valid = 1'b0; out_ready = 1'b0;
        #2;
        check("pp_count", 64'(count), 64'd4);
        check("pp_wp", 64'(write_pointer), 64'd14);
        check("pp_rp", 64'(read_pointer), 64'd10);
        step();

        // Flush with a pending request at count 7.
        do_clr();
        push_n(7);
        req0_valid = 1'b1; clr = 1'b1; out_ready = 1'b1;
        #2;
        check("clr_ready", 64'(req0_ready), 64'd0);
        check("clr_load_en", 64'(load_en), 64'd0);
        step();
        clr = 1'b0; req0_valid = 1'b0; out_ready = 1'b0;
        #2;
        check("clr_count", 64'(count), 64'd0);
        check("clr_ptrs", 64'({write_pointer, read_pointer}), 64'd0);
        check("clr_out_valid", 64'(out_valid), 64'd0);
        step();

        // Randomized traffic honouring the hold-while-not-ready rule.
        for (int i = 0; i < 800; i++) begin
            int mode;
            mode = i / 200;
            if (!pend0) begin req0_valid = ($urandom_range(0, 3) != 0); rand_req0(); end
            if (!pend1) begin req1_valid = ($urandom_range(0, 3) < (mode == 1 ? 3 : 2)); rand_req1(); end
            out_ready = (mode == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 99) < 2);
            step();
        end
        clr = 1'b0; out_ready = 1'b0; req1_valid = 1'b0;

        // Asynchronous reset in the middle of a push.
        push_n(3);
        req0_valid = 1'b1; rand_req0();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        req0_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
